// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: parameter defaults and the
// FSM state encoding used by the top-level controller.
package counter_sequencer_pkg;

    localparam int WIDTH_DEF        = 8;
    localparam int STALL_CYCLES_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_PAUSE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
    localparam state_t ST_CLR   = 3'd5;
    localparam state_t ST_ERR   = 3'd6;

endpackage

// File: rtl/counter_stall_monitor.sv
// Watchdog for the external counter: counts consecutive running cycles in
// which ctr_count did not move and flags the cycle that reaches the limit.
module counter_stall_monitor
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
    input  logic             i_clock,
    input  logic             i_clear_n,
    input  logic [WIDTH-1:0] i_ctr_count,
    input  logic             i_run_active,
    input  logic             i_load,
    output logic             o_stall
);

    localparam int CW = $clog2(STALL_CYCLES + 1);
    localparam logic [CW-1:0] STALL_TC  = CW'(STALL_CYCLES - 1);
    localparam logic [CW-1:0] STALL_MAX = CW'(STALL_CYCLES);

    logic [WIDTH-1:0] r_prev;
    logic [CW-1:0]    r_cnt;
    logic             w_same;

    assign w_same = (i_ctr_count == r_prev);

    // Remember last cycle's counter value to detect movement.
    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_ctr_count;
        end
    end

    // Unchanged-cycle counter; held (not cleared) while the counter is idle.
    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_cnt <= '0;
        end else if (i_load || !w_same) begin
            r_cnt <= '0;
        end else if (i_run_active && (r_cnt != STALL_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Stall fires on the unchanged running cycle that completes the window.
    always_comb begin
        o_stall = i_run_active && w_same && (r_cnt == STALL_TC);
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer for an external loadable up-counter: load a preset, run to a
// limit, pulse done; supports pause, abort, auto-reload and a stall watchdog.
//
//   state | meaning
//   IDLE  | waiting for start, counter untouched
//   LOAD  | ctr_load asserted, counter takes preset this edge
//   RUN   | counting until ctr_count == limit
//   PAUSE | counting suspended, resume with start
//   DONE  | one-cycle done pulse, optional reload
//   CLR   | one-cycle ctr_clear after abort
//   ERR   | watchdog tripped, wait for abort
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
    input  logic             i_clock,
    input  logic             i_clear_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_abort,
    input  logic             i_auto_reload,
    input  logic [WIDTH-1:0] i_preset,
    input  logic [WIDTH-1:0] i_limit,
    input  logic [WIDTH-1:0] i_ctr_count,
    output logic             o_ctr_clear,
    output logic             o_ctr_load,
    output logic [WIDTH-1:0] o_ctr_data,
    output logic             o_ctr_run,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stalled,
    output logic [7:0]       o_reload_cnt
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_preset_q;
    logic [WIDTH-1:0] r_limit_q;
    logic             r_auto_q;
    logic [7:0]       r_reload_cnt;
    logic             w_at_limit;
    logic             w_stall;
    logic             w_start_job;
    logic             w_reload;

    assign w_at_limit  = (i_ctr_count == r_limit_q);
    assign w_start_job = (r_state == ST_IDLE) && !i_abort && i_start;
    assign w_reload    = (r_state == ST_DONE) && !i_abort && r_auto_q && !i_stop;

    // State register.
    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort always wins, then stop, then start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_abort)      w_state_next = ST_CLR;
                else if (i_start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (i_abort) w_state_next = ST_CLR;
                else         w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_abort)         w_state_next = ST_CLR;
                else if (w_at_limit) w_state_next = ST_DONE;
                else if (i_stop)     w_state_next = ST_PAUSE;
                else if (w_stall)    w_state_next = ST_ERR;
            end
            ST_PAUSE: begin
                if (i_abort)                w_state_next = ST_CLR;
                else if (i_start && !i_stop) w_state_next = ST_RUN;
            end
            ST_DONE: begin
                if (i_abort)       w_state_next = ST_CLR;
                else if (w_reload) w_state_next = ST_LOAD;
                else               w_state_next = ST_IDLE;
            end
            ST_CLR: w_state_next = ST_IDLE;
            ST_ERR: begin
                if (i_abort) w_state_next = ST_CLR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Job parameters captured at start, plus the saturating reload counter.
    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_preset_q   <= '0;
            r_limit_q    <= '0;
            r_auto_q     <= 1'b0;
            r_reload_cnt <= '0;
        end else if (w_start_job) begin
            r_preset_q   <= i_preset;
            r_limit_q    <= i_limit;
            r_auto_q     <= i_auto_reload;
            r_reload_cnt <= '0;
        end else if (w_reload && (r_reload_cnt != 8'hFF)) begin
            r_reload_cnt <= r_reload_cnt + 8'd1;
        end
    end

    // Output decode; ctr_run drops combinationally at the limit so the
    // counter can never step past it.
    always_comb begin
        o_ctr_load   = (r_state == ST_LOAD);
        o_ctr_clear  = (r_state == ST_CLR);
        o_done       = (r_state == ST_DONE);
        o_busy       = (r_state != ST_IDLE);
        o_stalled    = (r_state == ST_ERR);
        o_ctr_run    = (r_state == ST_RUN) && !w_at_limit;
        o_ctr_data   = r_preset_q;
        o_reload_cnt = r_reload_cnt;
    end

    counter_stall_monitor #(
        .WIDTH        (WIDTH),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall_monitor (
        .i_clock      (i_clock),
        .i_clear_n    (i_clear_n),
        .i_ctr_count  (i_ctr_count),
        .i_run_active (o_ctr_run),
        .i_load       (o_ctr_load),
        .o_stall      (w_stall)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: ideal external counter plus job-level
// expectations (run cycles, done pulses, reload count) derived from the
// preset/limit arithmetic.
module tb_counter_sequencer;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       abort = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] preset = 8'h00;
    logic [7:0] limit = 8'h00;
    logic [7:0] ctr_count = 8'h00;
    logic       ctr_clear, ctr_load, ctr_run, busy, done, stalled;
    logic [7:0] ctr_data, reload_cnt;
    bit         freeze = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    counter_sequencer #(.WIDTH(8), .STALL_CYCLES(16)) dut (
        .i_clock       (clock),
        .i_clear_n     (clear_n),
        .i_start       (start),
        .i_stop        (stop),
        .i_abort       (abort),
        .i_auto_reload (auto_reload),
        .i_preset      (preset),
        .i_limit       (limit),
        .i_ctr_count   (ctr_count),
        .o_ctr_clear   (ctr_clear),
        .o_ctr_load    (ctr_load),
        .o_ctr_data    (ctr_data),
        .o_ctr_run     (ctr_run),
        .o_busy        (busy),
        .o_done        (done),
        .o_stalled     (stalled),
        .o_reload_cnt  (reload_cnt)
    );

    // Ideal external counter; freeze models a dead counter.
    always @(posedge clock) begin
        if (!freeze) begin
            if (ctr_clear)     ctr_count <= 8'h00;
            else if (ctr_load) ctr_count <= ctr_data;
            else if (ctr_run)  ctr_count <= ctr_count + 8'h01;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One job: expected run cycles per pass = (limit - preset) mod 256.
    task automatic run_job(input logic [7:0] p, input logic [7:0] l, input bit auto_r,
                           input int passes, input int pause_k);
        logic [7:0] span8;
        logic [7:0] hold_val;
        int runs, dones, pause_left, cyc;
        bit was_load;
        span8 = l - p;
        runs = 0; dones = 0; pause_left = 0; cyc = 0; hold_val = 8'h00;
        preset = p; limit = l; auto_reload = auto_r; start = 1'b1;
        step();
        start = 1'b0;
        chk("load_pulse", 32'(ctr_load), 1);
        chk("busy_load", 32'(busy), 1);
        was_load = 1'b1;
        while (cyc < 3000) begin
            step();
            cyc++;
            start = 1'b0;
            if (!busy) break;
            if (was_load) chk("first_run_val", 32'(ctr_count), 32'(p));
            was_load = ctr_load;
            if (pause_left > 0) begin
                chk("pause_run", 32'(ctr_run), 0);
                chk("pause_hold", 32'(ctr_count), 32'(hold_val));
                pause_left--;
                if (pause_left == 0) begin
                    stop = 1'b0;
                    start = 1'b1;
                end
            end else begin
                if (ctr_run) begin
                    runs++;
                    if (pause_k != 0 && runs == pause_k && dones == 0) begin
                        stop = 1'b1;
                        pause_left = 3;
                        hold_val = p + 8'(pause_k);
                    end
                end
                if (done) begin
                    dones++;
                    chk("done_val", 32'(ctr_count), 32'(l));
                    if (auto_r && dones >= passes) stop = 1'b1;
                end
            end
        end
        stop = 1'b0;
        chk("job_timeout", 32'(cyc < 3000), 1);
        chk("run_cycles", runs, passes * int'(span8));
        chk("done_pulses", dones, passes);
        chk("reload_cnt", 32'(reload_cnt), auto_r ? passes - 1 : 0);
        chk("no_stall", 32'(stalled), 0);
        chk("final_count", 32'(ctr_count), 32'(l));
        step();
    endtask

    initial begin
        logic [7:0] p, l, v, span;
        int runs, pk, passes;
        bit a;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_run", 32'(ctr_run), 0);
        chk("rst_data", 32'(ctr_data), 0);
        chk("rst_reload", 32'(reload_cnt), 0);
        clear_n = 1'b1;
        step();

        // Directed jobs: one-shot, pause at 07, auto-reload, wrap, preset==limit.
        run_job(8'h05, 8'h09, 1'b0, 1, 0);
        run_job(8'h03, 8'h0C, 1'b0, 1, 4);
        run_job(8'h00, 8'h03, 1'b1, 3, 0);
        run_job(8'hFE, 8'h01, 1'b0, 1, 0);
        run_job(8'h40, 8'h40, 1'b0, 1, 0);

        // Abort in RUN at count 02.
        preset = 8'h00; limit = 8'h32; auto_reload = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("abort_at", 32'(ctr_count), 32'h02);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_clr", 32'(ctr_clear), 1);
        chk("abort_run", 32'(ctr_run), 0);
        step();
        chk("abort_clr_once", 32'(ctr_clear), 0);
        chk("abort_idle", 32'(busy), 0);
        chk("abort_cleared", 32'(ctr_count), 0);

        // Abort together with start in IDLE.
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        chk("abst_clr", 32'(ctr_clear), 1);
        chk("abst_noload", 32'(ctr_load), 0);
        step();
        chk("abst_idle", 32'(busy), 0);

        // Stall: counter frozen at 33 while the job expects 10..40.
        step();
        freeze = 1'b1;
        ctr_count = 8'h33;
        preset = 8'h10; limit = 8'h40; start = 1'b1;
        step();
        start = 1'b0;
        runs = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (stalled) break;
            if (ctr_run) runs++;
        end
        chk("stall_seen", 32'(stalled), 1);
        chk("stall_cycles", runs, 16);
        for (int i = 0; i < int'($urandom_range(3, 8)); i++) begin
            step();
            chk("stall_sticky", 32'(stalled), 1);
            chk("stall_norun", 32'(ctr_run), 0);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        freeze = 1'b0;
        chk("stall_clr", 32'(ctr_clear), 1);
        chk("stall_cleared", 32'(stalled), 0);
        step();
        chk("stall_idle", 32'(busy), 0);
        chk("stall_cnt0", 32'(ctr_count), 0);

        // Randomized jobs.
        for (int n = 0; n < 24; n++) begin
            p = 8'($urandom);
            l = ($urandom_range(0, 1) == 1) ? p + 8'($urandom_range(0, 40)) : 8'($urandom);
            a = ($urandom_range(0, 1) == 1);
            passes = a ? int'($urandom_range(1, 3)) : 1;
            span = l - p;
            pk = (span != 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, int'(span))) : 0;
            run_job(p, l, a, passes, pk);
        end

        // Asynchronous reset in the middle of RUN.
        preset = 8'h10; limit = 8'hF0; auto_reload = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        #3;
        clear_n = 1'b0;
        #1;
        chk("arst_run", 32'(ctr_run), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_load", 32'(ctr_load), 0);
        chk("arst_data", 32'(ctr_data), 0);
        v = ctr_count;
        step();
        chk("arst_frozen", 32'(ctr_count), 32'(v));
        clear_n = 1'b1;
        step();
        chk("arst_idle", 32'(busy), 0);
        chk("arst_reload", 32'(reload_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
